// File: rtl/uart_tx_sched_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_sched_pkg
// Shared types and helpers for the UART transmit scheduler.
//   state_e    : scheduler FSM states (IDLE / START / DRAIN)
//   BYTE_W     : width of one transmitted byte
//   MAX_REQ    : largest supported requester count
//   rr_winner(): round-robin winner index from (valid mask, pointer)
// ----------------------------------------------------------------------------
package uart_tx_sched_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_IDW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // First set bit of mask found when scanning ptr, ptr+1, ... (mod n).
    // Returns ptr when nothing is set; callers qualify with |mask.
    function automatic int unsigned rr_winner(input logic [MAX_REQ-1:0] mask,
                                              input int unsigned        ptr,
                                              input int unsigned        n);
        logic [MAX_IDW-1:0] idx;
        int unsigned        win;
        logic               hit;
        win = ptr;
        hit = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = MAX_IDW'((ptr + k) % n);
            if ((k < n) && !hit && mask[idx]) begin
                win = 32'(idx);
                hit = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder for the UART transmit scheduler.
//   mask_i  : eligible requesters (valid already masked by packet lock)
//   ptr_i   : requester with highest priority this round
//   win_o   : index of the winning requester
//   found_o : at least one requester is eligible
// ----------------------------------------------------------------------------
module rr_pick
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     win_o,
    output logic               found_o
);

    always_comb begin
        found_o = |mask_i;
        win_o   = IDW'(rr_winner(MAX_REQ'(mask_i), 32'(ptr_i), NUM_REQ));
    end

endmodule

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter core among NUM_REQ byte
// producers. A requester keeps the grant until the byte flagged req_last.
//
// Ports
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   req_valid/req_data/req_last : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready          : one-hot registered acceptance pulse
//   tx_start, tx_data  : start request and byte to the UART core
//   tx_clear_req       : core has latched tx_data
//   tx_busy            : core is shifting
//   grant_id           : current / last granted requester
//   timeout_err        : one-cycle abort pulse
//
// Build option: define UART_TX_SCHED_TIMEOUT_EN to enable the START/DRAIN
// watchdog (TIMEOUT_CYC cycles); otherwise timeout_err is tied low.
// ----------------------------------------------------------------------------
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_start,
    output logic [BYTE_W-1:0]           tx_data,
    input  logic                        tx_clear_req,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        timeout_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    state_e                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic                   lock_q, lock_d;
    logic [IDW-1:0]         grant_q, grant_d;
    logic [BYTE_W-1:0]      data_q, data_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic                   start_q, start_d;

    logic [BYTE_W-1:0]      req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]     eligible;
    logic [IDW-1:0]         win;
    logic                   found;
    logic [IDW-1:0]         next_ptr;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [31:0]            cnt_q, cnt_d;
    logic                   tout_q, tout_d;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
    end

    // While a packet is open only its owner may be picked.
    assign eligible = lock_q ? (req_valid & (NUM_REQ'(1) << grant_q)) : req_valid;
    assign next_ptr = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .mask_i  (eligible),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .found_o (found)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            lock_q  <= 1'b0;
            grant_q <= '0;
            data_q  <= '0;
            ready_q <= '0;
            start_q <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            start_q <= start_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        grant_d = grant_q;
        data_d  = data_q;
        ready_d = '0;
        start_d = start_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                start_d = 1'b0;
                if (!tx_busy && found) begin
                    ready_d = NUM_REQ'(1) << win;
                    data_d  = req_bytes[win];
                    grant_d = win;
                    lock_d  = ~req_last[win];
                    start_d = 1'b1;
                    state_d = ST_START;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_START: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (tx_clear_req) begin
                    start_d = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                    // Pointer only moves once the packet is closed.
                    if (!lock_q) begin
                        ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog overrides whatever START/DRAIN decided this cycle.
        if ((state_q != ST_IDLE) && (cnt_q == TIMEOUT_CYC)) begin
            start_d = 1'b0;
            state_d = ST_IDLE;
            lock_d  = 1'b0;
            ptr_d   = next_ptr;
            tout_d  = 1'b1;
            cnt_d   = '0;
        end
`endif
    end

    assign req_ready = ready_q;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign grant_id  = grant_q;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign timeout_err = tout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign timeout_err        = 1'b0;
`endif

endmodule
